// File: rtl/tlc_param.sv
// tlc_param: parametrised two-road traffic light controller.
// Moore FSM cycling H green/yellow/(left)/all-red then V green/yellow/(left)/all-red,
// with demand-inserted left-turn phases, all-red clearance and a night flash mode.
// Ports:
//   clk                     system clock, rising edge
//   reset                   asynchronous active-high reset
//   h_left_req, v_left_req  left-turn demand per road (level or pulse)
//   flash_en                night flash request (level)
//   Horizontal_*/Vertical_* lamp outputs, decoded from state and blink bit
//   phase                   current state code
module tlc_param #(
  parameter int unsigned G_TIME     = 8,
  parameter int unsigned Y_TIME     = 2,
  parameter int unsigned L_TIME     = 4,
  parameter int unsigned AR_TIME    = 1,
  parameter int unsigned FLASH_HALF = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_left_req,
  input  logic       v_left_req,
  input  logic       flash_en,
  output logic       Horizontal_Green,
  output logic       Horizontal_Yellow,
  output logic       Horizontal_Left,
  output logic       Horizontal_Red,
  output logic       Vertical_Green,
  output logic       Vertical_Yellow,
  output logic       Vertical_Left,
  output logic       Vertical_Red,
  output logic [3:0] phase
);

  localparam int unsigned ST_W = 4;

  localparam logic [3:0] S_START = 4'd0;
  localparam logic [3:0] S_H_G   = 4'd1;
  localparam logic [3:0] S_H_Y   = 4'd2;
  localparam logic [3:0] S_H_L   = 4'd3;
  localparam logic [3:0] S_H_AR  = 4'd4;
  localparam logic [3:0] S_V_G   = 4'd5;
  localparam logic [3:0] S_V_Y   = 4'd6;
  localparam logic [3:0] S_V_L   = 4'd7;
  localparam logic [3:0] S_V_AR  = 4'd8;
  localparam logic [3:0] S_FLASH = 4'd9;

  logic [ST_W-1:0]  state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             hl_latch, hl_latch_nxt;
  logic             vl_latch, vl_latch_nxt;
  logic             blink, blink_nxt;
  logic             expire;

  // Reload value (duration minus one) for the state being entered.
  function automatic logic [CNT_W-1:0] reload(input logic [ST_W-1:0] s);
    case (s)
      S_H_G, S_V_G: reload = CNT_W'(G_TIME - 1);
      S_H_Y, S_V_Y: reload = CNT_W'(Y_TIME - 1);
      S_H_L, S_V_L: reload = CNT_W'(L_TIME - 1);
      S_FLASH:      reload = CNT_W'(FLASH_HALF - 1);
      default:      reload = CNT_W'(AR_TIME - 1);
    endcase
  endfunction

  // State, timer, latches and blink register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_START;
      timer    <= CNT_W'(AR_TIME - 1);
      hl_latch <= 1'b0;
      vl_latch <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      hl_latch <= hl_latch_nxt;
      vl_latch <= vl_latch_nxt;
      blink    <= blink_nxt;
    end
  end

  assign expire = (timer == '0);

  // Next-state, timer reload and latch bookkeeping.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer - CNT_W'(1);
    hl_latch_nxt = hl_latch;
    vl_latch_nxt = vl_latch;
    blink_nxt    = blink;

    // Demand is only captured while its own road is green or yellow.
    if ((state == S_H_G || state == S_H_Y) && h_left_req) hl_latch_nxt = 1'b1;
    if ((state == S_V_G || state == S_V_Y) && v_left_req) vl_latch_nxt = 1'b1;

    if (state == S_FLASH) begin
      if (!flash_en) begin
        state_nxt = S_START;
        timer_nxt = reload(S_START);
        blink_nxt = 1'b0;
      end else if (expire) begin
        blink_nxt = ~blink;
        timer_nxt = reload(S_FLASH);
      end
    end else if (expire) begin
      case (state)
        S_START: state_nxt = flash_en ? S_FLASH : S_H_G;
        S_H_G:   state_nxt = S_H_Y;
        // Latch OR live request so a request on the last yellow cycle counts.
        S_H_Y:   state_nxt = (hl_latch | h_left_req) ? S_H_L : S_H_AR;
        S_H_L:   state_nxt = S_H_AR;
        S_H_AR:  state_nxt = flash_en ? S_FLASH : S_V_G;
        S_V_G:   state_nxt = S_V_Y;
        S_V_Y:   state_nxt = (vl_latch | v_left_req) ? S_V_L : S_V_AR;
        S_V_L:   state_nxt = S_V_AR;
        S_V_AR:  state_nxt = flash_en ? S_FLASH : S_H_G;
        default: state_nxt = S_START;
      endcase
      timer_nxt = reload(state_nxt);
      if (state_nxt == S_H_AR) hl_latch_nxt = 1'b0;
      if (state_nxt == S_V_AR) vl_latch_nxt = 1'b0;
      if (state_nxt == S_FLASH) blink_nxt = 1'b1;
    end

    // Left demand is meaningless while flashing.
    if (state == S_FLASH || state_nxt == S_FLASH) begin
      hl_latch_nxt = 1'b0;
      vl_latch_nxt = 1'b0;
    end
  end

  // Lamp decode from registered state and blink bit.
  always_comb begin
    Horizontal_Green  = 1'b0;
    Horizontal_Yellow = 1'b0;
    Horizontal_Left   = 1'b0;
    Horizontal_Red    = 1'b0;
    Vertical_Green    = 1'b0;
    Vertical_Yellow   = 1'b0;
    Vertical_Left     = 1'b0;
    Vertical_Red      = 1'b0;
    case (state)
      S_H_G:   begin Horizontal_Green  = 1'b1; Vertical_Red   = 1'b1; end
      S_H_Y:   begin Horizontal_Yellow = 1'b1; Vertical_Red   = 1'b1; end
      S_H_L:   begin Horizontal_Left   = 1'b1; Vertical_Red   = 1'b1; end
      S_V_G:   begin Vertical_Green    = 1'b1; Horizontal_Red = 1'b1; end
      S_V_Y:   begin Vertical_Yellow   = 1'b1; Horizontal_Red = 1'b1; end
      S_V_L:   begin Vertical_Left     = 1'b1; Horizontal_Red = 1'b1; end
      S_FLASH: begin Horizontal_Yellow = blink; Vertical_Red  = blink; end
      default: begin Horizontal_Red    = 1'b1; Vertical_Red   = 1'b1; end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_tlc_param.sv
// tb_tlc_param: scoreboard bench for tlc_param. Instance 0 uses default timing with
// directed and random stimulus; instance 1 uses short timing with both left requests held.
`timescale 1ns/1ps
module tb_tlc_param;

  logic clk;
  logic reset;
  logic h_req0, v_req0, flash0;
  logic [3:0] ph0, ph1;
  logic [7:0] lmp0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #50 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int GT = (g == 0) ? 8 : 3;
    localparam int YT = (g == 0) ? 2 : 1;
    localparam int LT = (g == 0) ? 4 : 1;
    localparam int AT = (g == 0) ? 1 : 2;
    localparam int FH = 2;

    logic hr, vr, fr;
    logic hg, hy, hl, hrd, vg, vy, vl, vrd;
    logic [3:0] ph;
    logic [7:0] lmp;

    assign hr  = (g == 0) ? h_req0 : 1'b1;
    assign vr  = (g == 0) ? v_req0 : 1'b1;
    assign fr  = (g == 0) ? flash0 : 1'b0;
    assign lmp = {hg, hy, hl, hrd, vg, vy, vl, vrd};

    tlc_param #(
      .G_TIME(GT), .Y_TIME(YT), .L_TIME(LT), .AR_TIME(AT), .FLASH_HALF(FH), .CNT_W(8)
    ) dut (
      .clk(clk), .reset(reset),
      .h_left_req(hr), .v_left_req(vr), .flash_en(fr),
      .Horizontal_Green(hg), .Horizontal_Yellow(hy), .Horizontal_Left(hl),
      .Horizontal_Red(hrd), .Vertical_Green(vg), .Vertical_Yellow(vy),
      .Vertical_Left(vl), .Vertical_Red(vrd), .phase(ph)
    );

    // Reference model: current phase, cycles left in it, pending left demands, blink.
    int m_ph, m_rem, m_blink;
    bit m_hl, m_vl;
    logic [11:0] q[$];

    function automatic int dur(input int p);
      case (p)
        1, 5:    return GT;
        2, 6:    return YT;
        3, 7:    return LT;
        9:       return FH;
        default: return AT;
      endcase
    endfunction

    function automatic int succ(input int p, input bit h, input bit v, input bit f);
      case (p)
        0:       return f ? 9 : 1;
        1:       return 2;
        2:       return h ? 3 : 4;
        3:       return 4;
        4:       return f ? 9 : 5;
        5:       return 6;
        6:       return v ? 7 : 8;
        7:       return 8;
        8:       return f ? 9 : 1;
        default: return 0;
      endcase
    endfunction

    // Lamp pattern {HG,HY,HL,HR,VG,VY,VL,VR} for a phase.
    function automatic logic [7:0] lamps(input int p, input int b);
      logic bb;
      bb = (b != 0);
      case (p)
        1:       return 8'b1000_0001;
        2:       return 8'b0100_0001;
        3:       return 8'b0010_0001;
        5:       return 8'b0001_1000;
        6:       return 8'b0001_0100;
        7:       return 8'b0001_0010;
        9:       return {1'b0, bb, 5'b00000, bb};
        default: return 8'b0001_0001;
      endcase
    endfunction

    task automatic enter(input int p);
      m_ph  = p;
      m_rem = dur(p);
      if (p == 4) m_hl = 1'b0;
      if (p == 8) m_vl = 1'b0;
      if (p == 9) begin m_blink = 1; m_hl = 1'b0; m_vl = 1'b0; end
      if (p == 0) m_blink = 0;
    endtask

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        m_ph = 0; m_rem = AT; m_blink = 0; m_hl = 1'b0; m_vl = 1'b0;
        q.delete();
      end else begin
        if ((m_ph == 1 || m_ph == 2) && hr) m_hl = 1'b1;
        if ((m_ph == 5 || m_ph == 6) && vr) m_vl = 1'b1;
        if (m_ph == 9) begin
          if (!fr) enter(0);
          else begin
            m_rem--;
            if (m_rem == 0) begin m_blink = 1 - m_blink; m_rem = FH; end
          end
        end else begin
          m_rem--;
          if (m_rem == 0) enter(succ(m_ph, m_hl, m_vl, fr));
        end
      end
      q.push_back({4'(m_ph), lamps(m_ph, m_blink)});
    end

    // Monitor: compare DUT against the oldest expectation once per cycle.
    always @(negedge clk) begin
      logic [11:0] exp_v;
      if (q.size() > 0) begin
        exp_v = q.pop_front();
        checks++;
        if ({ph, lmp} !== exp_v) begin
          failures++;
          $display("FAIL inst%0d cyc %0d phase_lamps: got ph=%0d lamps=%b required ph=%0d lamps=%b",
                   g, cyc, ph, lmp, exp_v[11:8], exp_v[7:0]);
        end
      end
    end
  end

  assign ph0  = inst[0].ph;
  assign lmp0 = inst[0].lmp;
  assign ph1  = inst[1].ph;

  // Short-timing instance with both lefts held: H_G entries must be 14 cycles apart.
  int last_hg = -1;
  logic [3:0] prev_ph1 = 4'd0;
  always @(negedge clk) begin
    cyc++;
    if (reset) last_hg = -1;
    else if (ph1 == 4'd1 && prev_ph1 != 4'd1) begin
      if (last_hg >= 0) begin
        checks++;
        if (cyc - last_hg != 14) begin
          failures++;
          $display("FAIL period_inst1: got %0d cycles required 14", cyc - last_hg);
        end
      end
      last_hg = cyc;
    end
    prev_ph1 = ph1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_phase(input logic [3:0] p, input int maxc);
    int n;
    n = 0;
    while (ph0 !== p && n < maxc) begin @(posedge clk); #2; n++; end
    checks++;
    if (ph0 !== p) begin
      failures++;
      $display("FAIL wait_phase: got ph=%0d required ph=%0d within %0d cycles", ph0, p, maxc);
    end
  endtask

  initial begin
    reset = 1'b1; h_req0 = 1'b0; v_req0 = 1'b0; flash0 = 1'b0;
    #100 reset = 1'b0;
    tick(50);

    // Left pulse during H_G, then a cycle without request.
    wait_phase(4'd1, 40);
    tick(3); h_req0 = 1'b1; tick(1); h_req0 = 1'b0;
    tick(50);

    // Opposing-road request ignored; request on last H_Y cycle honoured.
    wait_phase(4'd1, 40);
    v_req0 = 1'b1; tick(1); v_req0 = 1'b0;
    wait_phase(4'd2, 20);
    tick(1); h_req0 = 1'b1; tick(1); h_req0 = 1'b0;
    tick(40);

    // Flash requested mid-V_G, held, then dropped.
    wait_phase(4'd5, 40);
    tick(2); flash0 = 1'b1;
    tick(25); flash0 = 1'b0;
    tick(30);

    // Asynchronous reset in the middle of H_L.
    wait_phase(4'd1, 40);
    h_req0 = 1'b1; tick(1); h_req0 = 1'b0;
    wait_phase(4'd3, 30);
    tick(1);
    #20 reset = 1'b1;
    #1;
    checks++;
    if (ph0 !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_phase: got %0d required 0", ph0);
    end
    checks++;
    if (lmp0 !== 8'b0001_0001) begin
      failures++;
      $display("FAIL async_reset_lamps: got %b required 00010001", lmp0);
    end
    @(posedge clk); #20 reset = 1'b0;
    tick(50);

    // Random demand and flash traffic.
    for (int i = 0; i < 600; i++) begin
      h_req0 = ($urandom_range(0, 9) == 0);
      v_req0 = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) flash0 = ~flash0;
      tick(1);
    end
    h_req0 = 1'b0; v_req0 = 1'b0; flash0 = 1'b0;
    tick(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
